// File: rtl/line_matrix_cfg_master.sv
// Line-matrix configuration initiator: turns route-write and clear commands into
// clk_pin / rstn / select sequences with fixed setup, strobe and hold timing.
module line_matrix_cfg_master #(
    parameter int unsigned SEL_W     = 4,
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned HIGH_CYC  = 4,
    parameter int unsigned HOLD_CYC  = 4,
    parameter int unsigned CLR_CYC   = 8
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_clear,
    input  logic [SEL_W-1:0] cmd_in_sel,
    input  logic [SEL_W-1:0] cmd_out_sel,
    output logic             busy,
    output logic [15:0]      wr_count,
    output logic             lm_clk_pin,
    output logic             lm_rstn,
    output logic [SEL_W-1:0] lm_input_select,
    output logic [SEL_W-1:0] lm_output_select
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSetup  = 3'd1;
    localparam logic [2:0] StStrobe = 3'd2;
    localparam logic [2:0] StHold   = 3'd3;
    localparam logic [2:0] StClear  = 3'd4;

    localparam int unsigned MaxSh  = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
    localparam int unsigned MaxHc  = (HOLD_CYC > CLR_CYC) ? HOLD_CYC : CLR_CYC;
    localparam int unsigned MaxCyc = (MaxSh > MaxHc) ? MaxSh : MaxHc;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] HighLd  = CntW'(HIGH_CYC - 1);
    localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYC - 1);
    localparam logic [CntW-1:0] ClrLd   = CntW'(CLR_CYC - 1);

    if (SEL_W == 0 || SETUP_CYC == 0 || HIGH_CYC == 0 || HOLD_CYC == 0 || CLR_CYC == 0)
    begin : gen_bad_param
        $error("line_matrix_cfg_master: all parameters must be at least 1");
    end

    logic [2:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             clk_pin_q, clk_pin_d;
    logic             lm_rstn_q, lm_rstn_d;
    logic [SEL_W-1:0] in_sel_q, in_sel_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic [15:0]      wr_count_q, wr_count_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clk_pin_d  = clk_pin_q;
        lm_rstn_d  = lm_rstn_q;
        in_sel_d   = in_sel_q;
        out_sel_d  = out_sel_q;
        wr_count_d = wr_count_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_clear) begin
                        state_d    = StClear;
                        cnt_d      = ClrLd;
                        lm_rstn_d  = 1'b0;
                        wr_count_d = 16'd0;
                    end else begin
                        state_d   = StSetup;
                        cnt_d     = SetupLd;
                        in_sel_d  = cmd_in_sel;
                        out_sel_d = cmd_out_sel;
                    end
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d    = StStrobe;
                    cnt_d      = HighLd;
                    clk_pin_d  = 1'b1;
                    wr_count_d = wr_count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    state_d   = StHold;
                    cnt_d     = HoldLd;
                    clk_pin_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StClear: begin
                if (cnt_q == '0) begin
                    state_d   = StIdle;
                    lm_rstn_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                // Unreachable encodings recover through a full clear.
                state_d    = StClear;
                cnt_d      = ClrLd;
                clk_pin_d  = 1'b0;
                lm_rstn_d  = 1'b0;
                wr_count_d = 16'd0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StClear;
            cnt_q      <= ClrLd;
            clk_pin_q  <= 1'b0;
            lm_rstn_q  <= 1'b0;
            in_sel_q   <= '0;
            out_sel_q  <= '0;
            wr_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk_pin_q  <= clk_pin_d;
            lm_rstn_q  <= lm_rstn_d;
            in_sel_q   <= in_sel_d;
            out_sel_q  <= out_sel_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign cmd_ready        = (state_q == StIdle);
    assign busy             = ~cmd_ready;
    assign wr_count         = wr_count_q;
    assign lm_clk_pin       = clk_pin_q;
    assign lm_rstn          = lm_rstn_q;
    assign lm_input_select  = in_sel_q;
    assign lm_output_select = out_sel_q;

endmodule
